bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one BUS_SIZE-wide datapath among CHANNELS
//   requesters. Owns the select of the shared channel mux: registers a one-hot
//   grant plus binary selector and forwards the granted channel's data. Sits
//   in front of shared CPU resources, e.g. the memory port between pipeline
//   and debug unit. Bounded ownership via a hold timeout.
//
// PARAMETERS
//   CHANNELS  2   number of requesters; must be >= 2
//   BUS_SIZE  32  width of each requester's data bus
//   MAX_HOLD  16  max consecutive cycles one owner may hold the bus; 0 = unlimited
//
// PORTS
//   clk       input   1                  single clock, rising edge
//   rst_n     input   1                  asynchronous, active-low reset
//   req       input   CHANNELS           per-channel request level
//   release   input   CHANNELS           per-channel end-of-transfer pulse
//   data_in   input   CHANNELS*BUS_SIZE  channel k at [k*BUS_SIZE +: BUS_SIZE]
//   grant     output  CHANNELS           one-hot owner, registered
//   selector  output  $clog2(CHANNELS)   binary index of owner, registered
//   data_out  output  BUS_SIZE           data_in of owner; 0 when no owner
//   busy      output  1                  1 while an owner holds the bus
//   timeout   output  1                  1-cycle pulse: ownership revoked by MAX_HOLD
//
// BEHAVIOUR
//   - Reset (rst_n=0, async, immediate): state=IDLE, grant=0, selector=0,
//     busy=0, timeout=0, hold counter=0, last_owner=CHANNELS-1 (ch0 first).
//   - States: IDLE, OWNED, RELEASE. busy=1 only in OWNED; grant=0 outside OWNED.
//   - IDLE/RELEASE: if req!=0 at edge, pick first set req scanning
//     last_owner+1, +2, ... mod CHANNELS; go OWNED, grant/selector/busy valid
//     the cycle after the sampling edge (1-cycle latency); hold counter=1.
//     If req==0, go/stay IDLE.
//   - OWNED: exit to RELEASE at the edge where release[owner]=1, or
//     req[owner]=0, or (MAX_HOLD!=0 and counter==MAX_HOLD); else counter+1.
//     On exit last_owner<=owner (owner becomes lowest priority).
//   - RELEASE lasts exactly one cycle, no grant (bus turnaround); it
//     arbitrates like IDLE, so handover gap is exactly 1 cycle.
//   - timeout=1 during the RELEASE cycle only when exit was caused by
//     MAX_HOLD with release[owner]=0 and req[owner]=1; else 0.
//   - Simultaneous release and limit hit: release wins, timeout=0.
//   - release/req of non-owner channels ignored for ownership; release in
//     IDLE/RELEASE ignored. Multiple grants never asserted.
//   - Revoked owner still requesting is re-granted only if no other channel
//     requests (round-robin order); counter restarts at 1.
//   - selector holds 0 when not busy; data_out combinational from registered
//     selector: data_in[selector*BUS_SIZE +: BUS_SIZE] when busy, else all 0.
//     Never drives X or Z.
//   - Counter width $clog2(MAX_HOLD+1) min 1; no wrap (exits at MAX_HOLD).
//
// TESTING  (CHANNELS=4, BUS_SIZE=32, MAX_HOLD=4 unless noted)
//   1. rst_n low mid-OWNED -> same-cycle grant=0, busy=0, selector=0,
//      data_out=0; after release of reset, req=4'b1111 -> ch0 granted first.
//   2. req=4'b0010 from IDLE -> next cycle grant=4'b0010, selector=1,
//      busy=1, data_out=data_in[63:32]=32'hA5A5_0001.
//   3. req=4'b1111 held, owner pulses release on its 2nd cycle -> grant order
//      0,1,2,3,0 with exactly one grant=0 cycle between owners, timeout=0.
//   4. Only ch2 requests, never releases -> grant 4 cycles, 1 RELEASE cycle
//      with timeout=1, ch2 re-granted; with ch3 also requesting -> ch3 next.
//   5. Owner ch1 drops req without release -> RELEASE next cycle, busy=0,
//      timeout=0; ch0 release pulses while ch1 owns -> no effect.
//   6. Release and MAX_HOLD hit on same edge -> RELEASE with timeout=0;
//      MAX_HOLD=0 run of 100 cycles without release -> no revocation.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that shares one BUS_SIZE-wide datapath among CHANNELS
// requesters. It registers a one-hot grant and a binary selector, and it
// forwards the data bus of the granted channel. A hold limit (MAX_HOLD)
// bounds how long one owner can keep the bus. MAX_HOLD = 0 means no limit.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-channel request level
//   release_in  per-channel end-of-transfer pulse; only the owner's bit counts
//   data_in     packed channel buses; channel k is at [k*BUS_SIZE +: BUS_SIZE]
//   grant       registered one-hot owner; all zero when there is no owner
//   selector    registered binary owner index; 0 when there is no owner
//   data_out    data bus of the owner; all zero when there is no owner
//   busy        high while an owner holds the bus
//   timeout     one-cycle pulse when the hold limit revokes ownership
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BUS_SIZE = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            release_in,
    input  logic [CHANNELS*BUS_SIZE-1:0]   data_in,
    output logic [CHANNELS-1:0]            grant,
    output logic [$clog2(CHANNELS)-1:0]    selector,
    output logic [BUS_SIZE-1:0]            data_out,
    output logic                           busy,
    output logic                           timeout
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    state_t              state_q,      state_d;
    logic [CHANNELS-1:0] grant_q,      grant_d;
    logic [SEL_W-1:0]    selector_q,   selector_d;
    logic                busy_q,       busy_d;
    logic                timeout_q,    timeout_d;
    logic [CNT_W-1:0]    hold_cnt_q,   hold_cnt_d;
    logic [SEL_W-1:0]    last_owner_q, last_owner_d;

    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic                owner_rel;
    logic                owner_req;
    logic                hold_hit;

    // Round-robin pick. The scan starts just after the last owner, so the
    // last owner is checked last and has the lowest priority.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = i + 32'(last_owner_q);
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (!pick_found && req[SEL_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        owner_rel = release_in[selector_q];
        owner_req = req[selector_q];
        hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

        state_d      = state_q;
        grant_d      = grant_q;
        selector_d   = selector_q;
        busy_d       = busy_q;
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;

        unique case (state_q)
            ST_IDLE, ST_RELEASE: begin
                // RELEASE arbitrates like IDLE. This keeps the handover gap
                // at exactly one cycle.
                if (pick_found) begin
                    state_d    = ST_OWNED;
                    grant_d    = CHANNELS'(1) << pick_idx;
                    selector_d = pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    selector_d = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            ST_OWNED: begin
                if (owner_rel || !owner_req || hold_hit) begin
                    state_d      = ST_RELEASE;
                    grant_d      = '0;
                    selector_d   = '0;
                    busy_d       = 1'b0;
                    hold_cnt_d   = '0;
                    last_owner_d = selector_q;
                    // If release and the hold limit hit on the same edge,
                    // release wins and no timeout pulse is sent.
                    timeout_d    = hold_hit && !owner_rel && owner_req;
                end else if (hold_cnt_q != '1) begin
                    // The counter saturates. This only matters when
                    // MAX_HOLD = 0 (no limit).
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                selector_d = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            selector_q   <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            hold_cnt_q   <= '0;
            last_owner_q <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            selector_q   <= selector_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // The output mux is driven from the registered selector and is gated by
    // busy. This means data_out is never X and is all zero when there is no
    // owner.
    always_comb begin
        data_out = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (busy_q && (selector_q == SEL_W'(k))) begin
                data_out = data_in[k*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

    assign grant    = grant_q;
    assign selector = selector_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Drives two bus_arbiter instances with the same stimulus: one with
// MAX_HOLD=4 and one with MAX_HOLD=0 (no limit). Both use CHANNELS=4 and
// BUS_SIZE=32. A reference model predicts the outputs after each edge. The
// prediction goes into a queue, and a monitor compares the queue against
// the DUT one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   rel = '0;
    logic [N*W-1:0] data_in = '0;

    logic [N-1:0] grant_a, grant_b;
    logic [1:0]   sel_a, sel_b;
    logic [W-1:0] dout_a, dout_b;
    logic         busy_a, busy_b, to_a, to_b;

    bus_arbiter #(.CHANNELS(N), .BUS_SIZE(W), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .release_in(rel), .data_in(data_in),
        .grant(grant_a), .selector(sel_a), .data_out(dout_a), .busy(busy_a), .timeout(to_a)
    );

    bus_arbiter #(.CHANNELS(N), .BUS_SIZE(W), .MAX_HOLD(0)) dut_nolimit (
        .clk(clk), .rst_n(rst_n), .req(req), .release_in(rel), .data_in(data_in),
        .grant(grant_b), .selector(sel_b), .data_out(dout_b), .busy(busy_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;   // -1: no owner
        int hold;    // cycles the current owner has held the bus
        int last;    // previous owner; it has the lowest priority
    } mstate_t;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   sel;
        logic         busy;
        logic         to;
        logic [W-1:0] data;
    } exp_t;

    exp_t    q_a[$];
    exp_t    q_b[$];
    mstate_t ms_a, ms_b;
    int      n_cmp = 0;
    int      n_err = 0;

    // Returns the outputs expected after the next edge and advances the model.
    function automatic exp_t model_step(inout mstate_t s, input int max_hold,
                                        input logic [N-1:0] r, input logic [N-1:0] rl,
                                        input logic [N*W-1:0] d);
        exp_t e;
        int   c;
        bit   lim;
        bit   done;
        e = '0;
        if (s.owner >= 0) begin
            lim = (max_hold != 0) && (s.hold >= max_hold);
            if (rl[s.owner] || !r[s.owner] || lim) begin
                e.to    = lim && !rl[s.owner] && r[s.owner];
                s.last  = s.owner;
                s.owner = -1;
                s.hold  = 0;
            end else begin
                s.hold = s.hold + 1;
            end
        end else begin
            done = 0;
            for (int k = 1; k <= N; k++) begin
                c = (s.last + k) % N;
                if (!done && r[c]) begin
                    s.owner = c;
                    s.hold  = 1;
                    done    = 1;
                end
            end
        end
        if (s.owner >= 0) begin
            e.grant = 4'b0001 << s.owner;
            e.sel   = 2'(s.owner);
            e.busy  = 1'b1;
            e.data  = d[s.owner*W +: W];
        end
        return e;
    endfunction

    task automatic check(input exp_t e, input exp_t got, input string name);
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s t=%0t: got grant=%b sel=%0d busy=%b timeout=%b data=%h, need grant=%b sel=%0d busy=%b timeout=%b data=%h",
                     name, $time, got.grant, got.sel, got.busy, got.to, got.data,
                     e.grant, e.sel, e.busy, e.to, e.data);
        end
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (q_a.size() > 0) check(q_a.pop_front(), {grant_a, sel_a, busy_a, to_a, dout_a}, "limit4");
            if (q_b.size() > 0) check(q_b.pop_front(), {grant_b, sel_b, busy_b, to_b, dout_b}, "nolimit");
        end
    end

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] rl, input logic [N*W-1:0] d);
        @(negedge clk);
        req     = r;
        rel     = rl;
        data_in = d;
        q_a.push_back(model_step(ms_a, 4, r, rl, d));
        q_b.push_back(model_step(ms_b, 0, r, rl, d));
    endtask

    task automatic model_reset();
        ms_a = '{owner: -1, hold: 0, last: N - 1};
        ms_b = '{owner: -1, hold: 0, last: N - 1};
    endtask

    // Asserts reset in the middle of a cycle. The outputs must clear in
    // that same cycle.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check('0, {grant_a, sel_a, busy_a, to_a, dout_a}, "async_reset_a");
        check('0, {grant_b, sel_b, busy_b, to_b, dout_b}, "async_reset_b");
        @(negedge clk);
        req = '0;
        rel = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   r, rl;

        model_reset();
        data_in = rnd_data();
        #2;
        check('0, {grant_a, sel_a, busy_a, to_a, dout_a}, "reset_a");
        check('0, {grant_b, sel_b, busy_b, to_b, dout_b}, "reset_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a channel owns the bus, then all channels request.
        drive(4'b1111, 4'b0000, rnd_data());
        drive(4'b1111, 4'b0000, rnd_data());
        reset_mid();
        for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0000, rnd_data());
        reset_mid();

        // Single request from channel 1, using a known data pattern.
        d = rnd_data();
        d[63:32] = 32'hA5A5_0001;
        for (int i = 0; i < 3; i++) drive(4'b0010, 4'b0000, d);
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, d);

        // All channels request; each owner releases on its 2nd cycle.
        for (int i = 0; i < 16; i++) begin
            rl = '0;
            if (ms_a.owner >= 0 && ms_a.hold == 2) rl = 4'b0001 << ms_a.owner;
            drive(4'b1111, rl, rnd_data());
        end
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, rnd_data());

        // Only channel 2 requests and never releases. Then channel 3 joins.
        for (int i = 0; i < 12; i++) drive(4'b0100, 4'b0000, rnd_data());
        for (int i = 0; i < 10; i++) drive(4'b1100, 4'b0000, rnd_data());
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, rnd_data());

        // Channel 1 owns the bus while channel 0 pulses release; then
        // channel 1 drops its request.
        for (int i = 0; i < 3; i++) drive(4'b0010, 4'b0001, rnd_data());
        drive(4'b0000, 4'b0000, rnd_data());
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, rnd_data());

        // Release arrives on the same edge as the hold-limit hit.
        for (int i = 0; i < 8; i++) begin
            rl = '0;
            if (ms_a.owner == 0 && ms_a.hold == 4) rl = 4'b0001;
            drive(4'b0001, rl, rnd_data());
        end
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, rnd_data());

        // Long hold with no release: the no-limit instance must keep the bus.
        for (int i = 0; i < 100; i++) drive(4'b0001, 4'b0000, rnd_data());
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, rnd_data());

        // Random traffic: request levels stay set for a while, and release
        // pulses are rare.
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            rl = '0;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(7) == 0) r[c] = ~r[c];
                if ($urandom_range(5) == 0) rl[c] = 1'b1;
            end
            drive(r, rl, rnd_data());
        end
        drive(4'b0000, 4'b0000, rnd_data());
        drive(4'b0000, 4'b0000, rnd_data());
        @(posedge clk);
        #3;

        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending, need 0/0", q_a.size(), q_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
